st_port_arbiter: RTL and testbench
==================================

Name: st_port_arbiter

Overview:
- Shares the single data-cache write request port between two requesters: the store-buffer drain (requester 0) and an auxiliary writer such as an AMO or debug path (requester 1).
- Captures one request into a holding register and presents it to the cache until granted.
- Tracks grants that have not yet been acknowledged and throttles new captures against a limit.
- Sits between the store unit's buffers and the dcache request port.

Parameters:
- PLEN, 34, physical address width.
- XLEN, 64, data width; byte-enable width is XLEN/8.
- MAX_OUTSTANDING, 4, maximum granted-but-unacknowledged writes; must be at least 1.
- STARVE_LIMIT, 4, consecutive requester-0 captures allowed while requester 1 is waiting; must be at least 1.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset; one clock, synchronous, active-high.
- stall_i, in, 1, blocks new captures; the holding register and the counter keep operating.
- sb_valid_i, in, 1, requester 0 has a write.
- sb_ready_o, out, 1, requester 0 write captured this cycle.
- sb_addr_i / sb_data_i / sb_be_i / sb_size_i, in, PLEN / XLEN / XLEN/8 / 2, requester 0 payload.
- aux_valid_i, in, 1, requester 1 has a write.
- aux_ready_o, out, 1, requester 1 write captured this cycle.
- aux_lock_i, in, 1, hold the port for requester 1 after this beat.
- aux_addr_i / aux_data_i / aux_be_i / aux_size_i, in, PLEN / XLEN / XLEN/8 / 2, requester 1 payload.
- dc_req_o, out, 1, cache request valid.
- dc_gnt_i, in, 1, cache accepted the request.
- dc_addr_o / dc_data_o / dc_be_o / dc_size_o, out, PLEN / XLEN / XLEN/8 / 2, registered payload.
- dc_src_o, out, 1, source of the current request (0 = sb, 1 = aux).
- dc_rvalid_i, in, 1, write acknowledge for the oldest grant.
- outstanding_o, out, $clog2(MAX_OUTSTANDING+1), granted-but-unacknowledged count.
- no_pending_o, out, 1, high when dc_req_o==0 and outstanding_o==0.

Behaviour:
- Reset values (synchronous, rst_i high at a clock edge, overrides every other event):
  - dc_req_o=0, all payload outputs=0, dc_src_o=0.
  - outstanding counter=0, starvation counter=0, lock=0.
  - no_pending_o=1, ready outputs=0.
  - A capture, grant or acknowledge in the reset cycle is discarded.
- Capture condition ("cap"): !stall_i && (!dc_req_o || dc_gnt_i) && (cnt_q + dc_req_o) < MAX_OUTSTANDING.
  - dc_rvalid_i is not used in cap; this is deliberately conservative.
- Selection when cap holds:
  - State LOCKED (lock_q=1): only aux may be selected. sb_ready_o=0.
  - Otherwise, if only one requester is valid, select it.
  - If both are valid, select sb unless starve_q==STARVE_LIMIT, in which case select aux.
- Capture:
  - The selected ready output is high combinationally in the same cycle. At most one ready output is high per cycle.
  - Payload and dc_src_o are registered. dc_req_o is high from the next cycle.
  - Latency: valid at cycle N with the port idle gives ready at N and dc_req_o at N+1.
- Hold: dc_req_o and the payload stay constant until dc_gnt_i.
  - A new capture may occur in the grant cycle, giving back-to-back requests.
- dc_gnt_i while dc_req_o==0 is ignored.
- Starvation counter:
  - On an sb capture while aux_valid_i=1: increment, saturating at STARVE_LIMIT.
  - On any aux capture, or on any cycle with aux_valid_i=0: clear.
- Lock:
  - An aux capture with aux_lock_i=1 sets lock_q.
  - An aux capture with aux_lock_i=0 clears lock_q.
  - lock_q is held across stall_i.
- Outstanding counter:
  - +1 on (dc_req_o && dc_gnt_i); -1 on dc_rvalid_i; unchanged when both occur in the same cycle.
  - dc_rvalid_i with cnt_q==0 and no grant: ignored, counter stays 0 (no underflow).
  - The counter never exceeds MAX_OUTSTANDING, guaranteed by cap.
- stall_i only blocks cap. A pending request is still presented and can still be granted.

Test Plan:
- Reset then sb write: sb_valid_i=1, addr=0x80, data=0xAA, be=0xFF at cycle 1 → sb_ready_o=1 at cycle 1; dc_req_o=1, dc_addr_o=0x80, dc_src_o=0 at cycle 2; gnt at cycle 3 → outstanding_o=1; rvalid at cycle 5 → outstanding_o=0 and no_pending_o=1.
- Outstanding limit (MAX_OUTSTANDING=4): sb_valid_i held, dc_gnt_i=1 every cycle, no rvalid → exactly 4 grants, then sb_ready_o stays 0. One rvalid pulse → one further capture.
- Starvation (STARVE_LIMIT=4): both valid continuously, gnt every cycle → capture order sb, sb, sb, sb, aux, then sb resumes.
- Lock: aux capture with lock=1, then aux_valid_i=0 for 3 cycles while sb_valid_i=1 → sb_ready_o stays 0. Aux capture with lock=0 → sb captured on the next eligible cycle.
- Simultaneous events and stall: grant and rvalid in the same cycle with cnt=2 → cnt stays 2. stall_i=1 with a pending request and gnt → request granted, no new capture. rvalid with cnt=0 → cnt stays 0.
- Reset mid-operation: rst_i=1 while dc_req_o=1 and cnt=3 → next cycle dc_req_o=0, outstanding_o=0, lock_q=0, no_pending_o=1.

Source files
------------

// File: rtl/st_port_arbiter.sv
// st_port_arbiter
// Shares the single dcache write-request port between the store-buffer drain
// (requester 0) and an auxiliary writer such as AMO/debug (requester 1).
// One request is captured into a holding register and presented until granted;
// granted-but-unacknowledged writes are counted and throttle new captures.
module st_port_arbiter #(
    parameter int unsigned PLEN            = 34,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 stall_i,

    input  logic                                 sb_valid_i,
    output logic                                 sb_ready_o,
    input  logic [PLEN-1:0]                      sb_addr_i,
    input  logic [XLEN-1:0]                      sb_data_i,
    input  logic [XLEN/8-1:0]                    sb_be_i,
    input  logic [1:0]                           sb_size_i,

    input  logic                                 aux_valid_i,
    output logic                                 aux_ready_o,
    input  logic                                 aux_lock_i,
    input  logic [PLEN-1:0]                      aux_addr_i,
    input  logic [XLEN-1:0]                      aux_data_i,
    input  logic [XLEN/8-1:0]                    aux_be_i,
    input  logic [1:0]                           aux_size_i,

    output logic                                 dc_req_o,
    input  logic                                 dc_gnt_i,
    output logic [PLEN-1:0]                      dc_addr_o,
    output logic [XLEN-1:0]                      dc_data_o,
    output logic [XLEN/8-1:0]                    dc_be_o,
    output logic [1:0]                           dc_size_o,
    output logic                                 dc_src_o,
    input  logic                                 dc_rvalid_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 no_pending_o
);

    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);

    generate
        if (MAX_OUTSTANDING < 1) begin : g_bad_max_outstanding
            $error("st_port_arbiter: MAX_OUTSTANDING must be at least 1");
        end
        if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
            $error("st_port_arbiter: STARVE_LIMIT must be at least 1");
        end
    endgenerate

    typedef enum logic {
        LOCK_OPEN,
        LOCK_HELD
    } lock_state_e;

    lock_state_e       lock_q, lock_d;

    logic              req_q, req_d;
    logic              src_q, src_d;
    logic [PLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [1:0]        size_q, size_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;

    logic [CNT_W:0]    inflight;
    logic              cap;
    logic              gnt_fire;
    logic              sel_sb;
    logic              sel_aux;
    logic              take_sb;
    logic              take_aux;

    // Capture eligibility: port free (or freeing this cycle) and room for one more.
    // The pending request counts against the limit since its grant may land now.
    always_comb begin
        gnt_fire = req_q && dc_gnt_i;
        inflight = {1'b0, cnt_q} + {{CNT_W{1'b0}}, req_q};
        cap      = !rst_i && !stall_i && (!req_q || dc_gnt_i) && (inflight < CNT_LIMIT);
    end

    // Lock state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= LOCK_OPEN;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Requester selection, ready generation and lock next-state.
    always_comb begin
        lock_d  = lock_q;
        sel_sb  = 1'b0;
        sel_aux = 1'b0;
        case (lock_q)
            LOCK_HELD: begin
                sel_aux = aux_valid_i;
            end
            default: begin
                if (sb_valid_i && aux_valid_i) begin
                    if (starve_q == STV_MAX) begin
                        sel_aux = 1'b1;
                    end else begin
                        sel_sb = 1'b1;
                    end
                end else begin
                    sel_sb  = sb_valid_i;
                    sel_aux = aux_valid_i;
                end
            end
        endcase
        take_sb  = cap && sel_sb;
        take_aux = cap && sel_aux;
        if (take_aux) begin
            lock_d = aux_lock_i ? LOCK_HELD : LOCK_OPEN;
        end
        sb_ready_o  = take_sb;
        aux_ready_o = take_aux;
    end

    // Holding register: load on capture, drop request on grant, otherwise hold.
    always_comb begin
        req_d  = req_q;
        src_d  = src_q;
        addr_d = addr_q;
        data_d = data_q;
        be_d   = be_q;
        size_d = size_q;
        if (take_sb) begin
            req_d  = 1'b1;
            src_d  = 1'b0;
            addr_d = sb_addr_i;
            data_d = sb_data_i;
            be_d   = sb_be_i;
            size_d = sb_size_i;
        end else if (take_aux) begin
            req_d  = 1'b1;
            src_d  = 1'b1;
            addr_d = aux_addr_i;
            data_d = aux_data_i;
            be_d   = aux_be_i;
            size_d = aux_size_i;
        end else if (gnt_fire) begin
            req_d  = 1'b0;
        end
    end

    // Holding register flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q  <= 1'b0;
            src_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            size_q <= '0;
        end else begin
            req_q  <= req_d;
            src_q  <= src_d;
            addr_q <= addr_d;
            data_q <= data_d;
            be_q   <= be_d;
            size_q <= size_d;
        end
    end

    // Outstanding counter: grant adds, acknowledge removes, both cancel; never underflows.
    always_comb begin
        cnt_d = cnt_q;
        if (gnt_fire && !dc_rvalid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!gnt_fire && dc_rvalid_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Starvation counter: counts sb wins while aux waits; any aux win or idle aux clears it.
    always_comb begin
        starve_d = starve_q;
        if (take_aux || !aux_valid_i) begin
            starve_d = '0;
        end else if (take_sb && (starve_q != STV_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Counter flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Output mapping.
    always_comb begin
        dc_req_o      = req_q;
        dc_src_o      = src_q;
        dc_addr_o     = addr_q;
        dc_data_o     = data_q;
        dc_be_o       = be_q;
        dc_size_o     = size_q;
        outstanding_o = cnt_q;
        no_pending_o  = !req_q && (cnt_q == '0);
    end

endmodule

// File: tb/tb_st_port_arbiter.sv
// Testbench for st_port_arbiter: directed stimulus, scoreboard queue of expected
// captured writes, and a monitor that checks each write as the cache grants it.
module tb_st_port_arbiter;

    localparam int PLEN  = 34;
    localparam int XLEN  = 64;
    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic             sbv = 1'b0;
    logic             sb_rdy;
    logic [PLEN-1:0]  sba = '0;
    logic [XLEN-1:0]  sbd = '0;
    logic [BE_W-1:0]  sbb = '0;
    logic [1:0]       sbs = '0;
    logic             auxv = 1'b0;
    logic             aux_rdy;
    logic             auxl = 1'b0;
    logic [PLEN-1:0]  auxa = '0;
    logic [XLEN-1:0]  auxd = '0;
    logic [BE_W-1:0]  auxb = '0;
    logic [1:0]       auxs = '0;
    logic             dc_req;
    logic             gnt = 1'b0;
    logic [PLEN-1:0]  dc_addr;
    logic [XLEN-1:0]  dc_data;
    logic [BE_W-1:0]  dc_be;
    logic [1:0]       dc_size;
    logic             dc_src;
    logic             rv = 1'b0;
    logic [CNT_W-1:0] outst;
    logic             no_pend;

    st_port_arbiter #(
        .PLEN(PLEN),
        .XLEN(XLEN),
        .MAX_OUTSTANDING(4),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .sb_valid_i(sbv), .sb_ready_o(sb_rdy),
        .sb_addr_i(sba), .sb_data_i(sbd), .sb_be_i(sbb), .sb_size_i(sbs),
        .aux_valid_i(auxv), .aux_ready_o(aux_rdy), .aux_lock_i(auxl),
        .aux_addr_i(auxa), .aux_data_i(auxd), .aux_be_i(auxb), .aux_size_i(auxs),
        .dc_req_o(dc_req), .dc_gnt_i(gnt),
        .dc_addr_o(dc_addr), .dc_data_o(dc_data), .dc_be_o(dc_be), .dc_size_o(dc_size),
        .dc_src_o(dc_src), .dc_rvalid_i(rv),
        .outstanding_o(outst), .no_pending_o(no_pend)
    );

    typedef struct packed {
        logic            src;
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every granted request must match the oldest expected capture.
    always @(negedge clk) begin
        txn_t t;
        if (!rst && dc_req && gnt) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant: got addr %0h expected none (t=%0t)", dc_addr, $time);
            end else begin
                t = exp_q.pop_front();
                chk("grant_src",  64'(dc_src),  64'(t.src));
                chk("grant_addr", 64'(dc_addr), 64'(t.addr));
                chk("grant_data", dc_data,      t.data);
                chk("grant_be",   64'(dc_be),   64'(t.be));
                chk("grant_size", 64'(dc_size), 64'(t.size));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_sb(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                          input logic [BE_W-1:0] b, input logic [1:0] s);
        sba = a; sbd = d; sbb = b; sbs = s;
    endtask

    task automatic set_aux(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                           input logic [BE_W-1:0] b, input logic [1:0] s);
        auxa = a; auxd = d; auxb = b; auxs = s;
    endtask

    task automatic push_sb();
        exp_q.push_back({1'b0, sba, sbd, sbb, sbs});
    endtask

    task automatic push_aux();
        exp_q.push_back({1'b1, auxa, auxd, auxb, auxs});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        txn_t dropped;

        // Reset: state cleared, request presented during reset is not captured.
        rst = 1'b1;
        sbv = 1'b1;
        set_sb(34'h11, 64'h11, 8'h01, 2'd0);
        at_neg();
        chk("rst_ready",   64'(sb_rdy), 64'(0));
        chk("rst_req",     64'(dc_req), 64'(0));
        chk("rst_outst",   64'(outst),  64'(0));
        chk("rst_nopend",  64'(no_pend), 64'(1));
        tick();
        rst = 1'b0;
        sbv = 1'b0;
        at_neg();
        chk("rst_discard", 64'(dc_req), 64'(0));
        tick();

        // Single sb write: ready same cycle, request next cycle, grant, ack.
        sbv = 1'b1;
        set_sb(34'h80, 64'hAA, 8'hFF, 2'd3);
        at_neg();
        chk("t1_ready", 64'(sb_rdy), 64'(1));
        chk("t1_auxrdy", 64'(aux_rdy), 64'(0));
        push_sb();
        tick();
        sbv = 1'b0;
        at_neg();
        chk("t1_req",  64'(dc_req),  64'(1));
        chk("t1_addr", 64'(dc_addr), 64'h80);
        chk("t1_src",  64'(dc_src),  64'(0));
        tick();
        gnt = 1'b1;
        at_neg();
        tick();
        gnt = 1'b0;
        at_neg();
        chk("t1_outst1",  64'(outst),   64'(1));
        chk("t1_req_off", 64'(dc_req),  64'(0));
        chk("t1_nopend0", 64'(no_pend), 64'(0));
        tick();
        rv = 1'b1;
        tick();
        rv = 1'b0;
        at_neg();
        chk("t1_outst0",  64'(outst),   64'(0));
        chk("t1_nopend1", 64'(no_pend), 64'(1));
        tick();

        // Outstanding limit: four captures with continuous grant, then blocked.
        sbv = 1'b1;
        gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_sb(34'h100 + 34'(i), 64'hB000 + 64'(i), 8'h0F, 2'd2);
            at_neg();
            chk("lim_ready", 64'(sb_rdy), 64'(i < 4));
            if (i < 4) push_sb();
            tick();
        end
        gnt = 1'b0;
        rv  = 1'b1;
        set_sb(34'h1FF, 64'hBFFF, 8'h0F, 2'd2);
        at_neg();
        chk("lim_full",    64'(outst),  64'(4));
        chk("lim_blocked", 64'(sb_rdy), 64'(0));
        tick();
        rv = 1'b0;
        set_sb(34'h200, 64'hC200, 8'hF0, 2'd1);
        at_neg();
        chk("lim_after_ack", 64'(outst),  64'(3));
        chk("lim_one_more",  64'(sb_rdy), 64'(1));
        push_sb();
        tick();
        sbv = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rv  = 1'b1;
        repeat (4) tick();
        rv = 1'b0;
        at_neg();
        chk("lim_drained", 64'(outst), 64'(0));
        tick();

        // Starvation: sb wins four times, then aux, then sb again.
        sbv  = 1'b1;
        auxv = 1'b1;
        auxl = 1'b0;
        gnt  = 1'b1;
        rv   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_sb(34'h300 + 34'(i), 64'hD300 + 64'(i), 8'h3C, 2'd1);
            set_aux(34'h400 + 34'(i), 64'hE400 + 64'(i), 8'hC3, 2'd0);
            at_neg();
            chk("stv_sb",  64'(sb_rdy),  64'(i != 4));
            chk("stv_aux", 64'(aux_rdy), 64'(i == 4));
            if (i == 4) push_aux(); else push_sb();
            tick();
        end
        sbv  = 1'b0;
        auxv = 1'b0;
        tick();
        gnt = 1'b0;
        rv  = 1'b0;
        at_neg();
        chk("stv_outst", 64'(outst), 64'(0));
        tick();

        // Lock: aux locks the port, sb excluded until aux releases it.
        gnt  = 1'b1;
        rv   = 1'b1;
        auxv = 1'b1;
        auxl = 1'b1;
        set_aux(34'h500, 64'hF500, 8'hFF, 2'd3);
        at_neg();
        chk("lk_aux_lock", 64'(aux_rdy), 64'(1));
        push_aux();
        tick();
        auxv = 1'b0;
        auxl = 1'b0;
        sbv  = 1'b1;
        set_sb(34'h510, 64'hF510, 8'h01, 2'd0);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("lk_sb_held", 64'(sb_rdy), 64'(0));
            tick();
        end
        auxv = 1'b1;
        auxl = 1'b0;
        set_aux(34'h520, 64'hF520, 8'h0F, 2'd2);
        at_neg();
        chk("lk_aux_unlock", 64'(aux_rdy), 64'(1));
        chk("lk_sb_still",   64'(sb_rdy),  64'(0));
        push_aux();
        tick();
        auxv = 1'b0;
        at_neg();
        chk("lk_sb_resume", 64'(sb_rdy), 64'(1));
        push_sb();
        tick();
        sbv = 1'b0;
        tick();
        gnt = 1'b0;
        rv  = 1'b0;

        // Simultaneous grant/ack and stall.
        sbv = 1'b1;
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_sb(34'h600 + 34'(i), 64'h1600 + 64'(i), 8'h80, 2'd0);
            at_neg();
            chk("sim_fill", 64'(sb_rdy), 64'(1));
            push_sb();
            tick();
        end
        rv = 1'b1;
        set_sb(34'h603, 64'h1603, 8'h40, 2'd0);
        at_neg();
        chk("sim_pre2",  64'(outst),  64'(2));
        chk("sim_ready", 64'(sb_rdy), 64'(1));
        push_sb();
        tick();
        rv    = 1'b0;
        stall = 1'b1;
        set_sb(34'h604, 64'h1604, 8'h20, 2'd0);
        at_neg();
        chk("sim_keep2",     64'(outst),  64'(2));
        chk("stall_noready", 64'(sb_rdy), 64'(0));
        chk("stall_req",     64'(dc_req), 64'(1));
        tick();
        stall = 1'b0;
        sbv   = 1'b0;
        gnt   = 1'b0;
        at_neg();
        chk("stall_granted", 64'(outst),  64'(3));
        chk("stall_no_cap",  64'(dc_req), 64'(0));
        tick();
        rv = 1'b1;
        repeat (4) tick();
        rv = 1'b0;
        at_neg();
        chk("underflow", 64'(outst),   64'(0));
        chk("uf_nopend", 64'(no_pend), 64'(1));
        tick();

        // Reset mid-operation with a locked, pending aux request and cnt=3.
        sbv = 1'b1;
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_sb(34'h700 + 34'(i), 64'h2700 + 64'(i), 8'h11, 2'd1);
            at_neg();
            chk("mr_fill", 64'(sb_rdy), 64'(1));
            push_sb();
            tick();
        end
        sbv  = 1'b0;
        auxv = 1'b1;
        auxl = 1'b1;
        set_aux(34'h7A0, 64'h27A0, 8'h22, 2'd1);
        at_neg();
        chk("mr_aux", 64'(aux_rdy), 64'(1));
        push_aux();
        tick();
        gnt  = 1'b0;
        auxv = 1'b0;
        auxl = 1'b0;
        rst  = 1'b1;
        at_neg();
        chk("mr_pre_req", 64'(dc_req), 64'(1));
        chk("mr_pre_cnt", 64'(outst),  64'(3));
        tick();
        rst = 1'b0;
        dropped = exp_q.pop_back();
        sbv = 1'b1;
        set_sb(34'h7F0, 64'h27F0, 8'h44, 2'd2);
        at_neg();
        chk("mr_req",     64'(dc_req),  64'(0));
        chk("mr_outst",   64'(outst),   64'(0));
        chk("mr_nopend",  64'(no_pend), 64'(1));
        chk("mr_addr",    64'(dc_addr), 64'(0));
        chk("mr_src",     64'(dc_src),  64'(0));
        chk("mr_unlocked", 64'(sb_rdy), 64'(1));
        push_sb();
        tick();
        sbv = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        at_neg();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
